tron_mem_ctrl: RTL and testbench

- Memory/I-O controller directly downstream of the Tron core.
- Consumes the core's address, store data and write strobe (addressOut/busOutput/memWrite), and returns load and fetch data with an acknowledge.
- Routes each request to an external synchronous block RAM or to a small memory-mapped I/O register set: LEDs, switches, free-running timer, status.
- Unmapped accesses set a sticky error flag.

---
 rtl/tron_mem_pkg.sv | 10 +
 rtl/tron_io_regs.sv | 53 +++++
 rtl/tron_mem_ctrl.sv | 108 ++++++++++
 tb/tb_tron_mem_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tron_mem_pkg.sv
// tron_mem_pkg: shared state encoding, address map and region bounds for the Tron memory controller
package tron_mem_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, DONE} state_t;
  localparam int          RAM_AW_DEF   = 14;
  localparam logic [15:0] IO_BASE_ADDR = 16'hFF00;
  localparam logic [1:0]  OFF_LED      = 2'd0;
  localparam logic [1:0]  OFF_SW       = 2'd1;
  localparam logic [1:0]  OFF_TIMER    = 2'd2;
  localparam logic [1:0]  OFF_STATUS   = 2'd3;
endpackage

// File: rtl/tron_io_regs.sv
// tron_io_regs: LED register, synchronized switches, free-running timer and sticky error flag
module tron_io_regs
  import tron_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic              err_set,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led_out,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] led_q, led_d, sw1_q, sw2_q, timer_q, timer_d;
  logic              err_q, err_d, wr;

  // Register updates; a timer clear and the unmapped-error set take priority over hold/increment
  always_comb begin
    wr      = sel && we;
    led_d   = (wr && off == OFF_LED) ? wdata : led_q;
    timer_d = (wr && off == OFF_TIMER) ? '0 : timer_q + 1'b1;
    err_d   = err_set ? 1'b1 : (wr && off == OFF_STATUS && wdata[0]) ? 1'b0 : err_q;
    rdata   = (off == OFF_LED)   ? led_q :
              (off == OFF_SW)    ? sw2_q :
              (off == OFF_TIMER) ? timer_q :
                                   {{(DATA_W-1){1'b0}}, err_q};
  end

  // State flops, including the two-stage switch synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      sw1_q   <= sw_in;
      sw2_q   <= sw1_q;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign led_out = led_q;
  assign err     = err_q;
endmodule

// File: rtl/tron_mem_ctrl.sv
// tron_mem_ctrl: routes core loads/stores to synchronous block RAM or memory-mapped I/O registers
module tron_mem_ctrl
  import tron_mem_pkg::*;
#(
  parameter int          RAM_AW  = RAM_AW_DEF,
  parameter int          DATA_W  = 16,
  parameter logic [15:0] IO_BASE = IO_BASE_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led_out
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, ram_wdata_q, ram_wdata_d, io_rdata;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ack_q, ack_d, ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic              is_ram, is_io, take, io_sel, err_set;

  assign is_ram  = (addr >> RAM_AW) == '0;
  assign is_io   = addr[15:2] == IO_BASE[15:2];
  assign take    = state_q == IDLE && req;
  assign io_sel  = take && is_io;
  assign err_set = take && !is_ram && !is_io;

  tron_io_regs #(.DATA_W(DATA_W)) u_io (
    .clk(clk), .reset(reset), .sel(io_sel), .we(we), .off(addr[1:0]),
    .wdata(wdata), .err_set(err_set), .sw_in(sw_in),
    .led_out(led_out), .err(err), .rdata(io_rdata)
  );

  // Next state: RAM reads take the wait/capture path, everything else completes straight to DONE
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        if (is_ram) ram_addr_d = addr[RAM_AW-1:0];
        if (is_ram && !we) begin
          ram_en_d = 1'b1;
          state_d  = RD_WAIT;
        end else begin
          ram_en_d = is_ram;
          ram_we_d = is_ram;
          ack_d    = 1'b1;
          state_d  = DONE;
          if (is_ram) ram_wdata_d = wdata;
          if (!we) rdata_d = is_io ? io_rdata : '0;
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = ram_rdata;
        ack_d   = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and FSM state; reset cancels any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_tron_mem_ctrl.sv
// tb_tron_mem_ctrl: directed table and sequence checks for the Tron memory controller
module tb_tron_mem_ctrl;
  logic        clk = 1'b0, reset = 1'b0, req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0, sw_in = '0, ram_rdata = '0;
  logic [15:0] rdata, ram_wdata, led_out;
  logic [13:0] ram_addr;
  logic        ack, busy, err, ram_en, ram_we;
  logic [15:0] mem [0:16383];
  int          errors = 0, checks = 0;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    int          exp_lat;
    logic [15:0] exp_led;
    logic        exp_err;
    logic        exp_en;
    logic        exp_we;
  } vec_t;
  vec_t tbl [16];

  tron_mem_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic en1, output logic we1);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; en1 = 1'b0; we1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin en1 = ram_en; we1 = ram_we; end
      if (ack) begin lat = i; break; end
    end
    req = 1'b0;
  endtask

  initial begin
    int   lat;
    logic en1, we1, seen;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    tbl[0]  = '{1'b1, 16'h0010, 16'h0005, 16'h0000, 1, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h0005, 3, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'h3FFF, 16'h1111, 16'h0005, 1, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 16'h3FFF, 16'h0000, 16'h1111, 3, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 16'hFF00, 16'h00A5, 16'h1111, 1, 16'h00A5, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'hFF00, 16'h0000, 16'h00A5, 1, 16'h00A5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'hFF01, 16'hFFFF, 16'h00A5, 1, 16'h00A5, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h4000, 16'h0000, 16'h0000, 1, 16'h00A5, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'hFF03, 16'h0000, 16'h0001, 1, 16'h00A5, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'hFF03, 16'h0001, 16'h0001, 1, 16'h00A5, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 16'hFF03, 16'h0000, 16'h0000, 1, 16'h00A5, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'hFF04, 16'h0000, 16'h0000, 1, 16'h00A5, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 16'hFF03, 16'h0000, 16'h0001, 1, 16'h00A5, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 16'h8000, 16'h1234, 16'h0001, 1, 16'h00A5, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 16'hFF03, 16'h0001, 16'h0001, 1, 16'h00A5, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 16'h0010, 16'h0000, 16'h0005, 3, 16'h00A5, 1'b0, 1'b1, 1'b0};

    #12;
    chk("por_rdata", rdata, 16'h0);
    chk("por_ack", ack, 1'b0);
    chk("por_busy", busy, 1'b0);
    chk("por_err", err, 1'b0);
    chk("por_led", led_out, 16'h0);
    chk("por_ram_en", ram_en, 1'b0);
    #11 reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      access(tbl[i].w, tbl[i].a, tbl[i].d, lat, en1, we1);
      chk($sformatf("row%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("row%0d_rdata", i), rdata, tbl[i].exp_rd);
      chk($sformatf("row%0d_led", i), led_out, tbl[i].exp_led);
      chk($sformatf("row%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("row%0d_ram_en", i), en1, tbl[i].exp_en);
      chk($sformatf("row%0d_ram_we", i), we1, tbl[i].exp_we);
    end

    sw_in = 16'h1234;
    repeat (2) @(posedge clk);
    access(1'b0, 16'hFF01, 16'h0, lat, en1, we1);
    chk("sw_read", rdata, 16'h1234);

    access(1'b1, 16'hFF02, 16'h0, lat, en1, we1);
    repeat (8) @(posedge clk);
    access(1'b0, 16'hFF02, 16'h0, lat, en1, we1);
    chk("timer_t10", rdata, 16'h0009);

    access(1'b1, 16'hFF02, 16'h0, lat, en1, we1);
    repeat (65533) @(posedge clk);
    access(1'b0, 16'hFF02, 16'h0, lat, en1, we1);
    chk("timer_fffe", rdata, 16'hFFFE);
    access(1'b0, 16'hFF02, 16'h0, lat, en1, we1);
    chk("timer_wrap", rdata, 16'h0000);

    access(1'b0, 16'h8000, 16'h0, lat, en1, we1);
    chk("unmapped_err", err, 1'b1);
    access(1'b0, 16'hFF00, 16'h0, lat, en1, we1);
    chk("pre_reset_rdata", rdata, 16'h00A5);
    #3 reset = 1'b0;
    #1;
    chk("rst_led", led_out, 16'h0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_ram_en", ram_en, 1'b0);
    #2 reset = 1'b1;

    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 16'h0010;
    @(posedge clk); #1;
    chk("flight_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("flight_busy", busy, 1'b0);
    chk("flight_ack", ack, 1'b0);
    chk("flight_ram_en", ram_en, 1'b0);
    req = 1'b0;
    #2 reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= ack;
    end
    chk("flight_no_ack", seen, 1'b0);
    access(1'b0, 16'h0010, 16'h0, lat, en1, we1);
    chk("flight_reread_lat", lat, 3);
    chk("flight_reread_data", rdata, 16'h0005);

    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'h7777;
    @(posedge clk); #1;
    chk("cancel_en_cycle", ram_we, 1'b1);
    #2 reset = 1'b0;
    #1 req = 1'b0;
    #2 reset = 1'b1;
    access(1'b0, 16'h0030, 16'h0, lat, en1, we1);
    chk("cancel_write_dropped", rdata, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
